// File: rtl/incdec_pkg.sv
// rtl/incdec_pkg.sv - shared op encodings and overflow-mode constants for the inc/dec accumulator
package incdec_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  localparam int SAT_WRAP     = 0;
  localparam int SAT_SATURATE = 1;

endpackage

// File: rtl/incdec_core.sv
// rtl/incdec_core.sv - combinational N+1 bit increment/decrement with carry/borrow in the MSB
module incdec_core #(
  parameter int N = 4
) (
  input  logic [N-1:0] y_i,
  input  logic         dec_i,
  output logic [N:0]   res_o
);

  logic [N:0] y_ext;
  logic [N:0] one_ext;

  assign y_ext   = {1'b0, y_i};
  assign one_ext = {{N{1'b0}}, 1'b1};

  // Zero-extended operand: an increment from all-ones and a decrement from
  // zero both land with the extra MSB set, so it doubles as carry or borrow.
  always_comb begin
    res_o = dec_i ? (y_ext - one_ext) : (y_ext + one_ext);
  end

endmodule

// File: rtl/incdec_acc_p.sv
// rtl/incdec_acc_p.sv - load/increment/decrement accumulator with wrap or saturate overflow
module incdec_acc_p
  import incdec_pkg::*;
#(
  parameter int N   = 4,
  parameter int SAT = SAT_WRAP
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   op,
  input  logic         Cin,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Y,
  output logic         Cout,
  output logic         Zout,
  output logic         Vld
);

  logic [N-1:0] y_q, y_d;
  logic         cout_q, cout_d;
  logic         vld_q, vld_d;
  logic [N:0]   step_res;
  logic         step_dec;

  // op[0] alone separates DEC from INC; for HOLD/LOAD the result is unused.
  assign step_dec = (op == OP_DEC);

  incdec_core #(.N(N)) u_core (
    .y_i   (y_q),
    .dec_i (step_dec),
    .res_o (step_res)
  );

  // Next-state selection: idle cycles hold Y and drop both pulses.
  always_comb begin
    y_d    = y_q;
    cout_d = 1'b0;
    vld_d  = 1'b0;
    if (en) begin
      vld_d = 1'b1;
      case (op)
        OP_HOLD: y_d = y_q;
        OP_LOAD: y_d = Cin ? B : A;
        OP_INC, OP_DEC: begin
          cout_d = step_res[N];
          if (SAT == SAT_SATURATE && step_res[N]) begin
            y_d = y_q;
          end else begin
            y_d = step_res[N-1:0];
          end
        end
        default: y_d = y_q;
      endcase
    end
  end

  // State registers; reset discards any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign Y    = y_q;
  assign Cout = cout_q;
  assign Vld  = vld_q;
  assign Zout = (y_q == '0);

endmodule

// File: tb/tb_incdec_acc_p.sv
// tb/tb_incdec_acc_p.sv - self-checking bench for incdec_acc_p in wrap and saturate modes
module tb_incdec_acc_p;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   op;
  logic         cin;
  logic [N-1:0] a, b;
  logic [N-1:0] y0, y1;
  logic         c0, c1, z0, z1, v0, v1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  incdec_acc_p #(.N(N), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .Cin(cin), .A(a), .B(b),
    .Y(y0), .Cout(c0), .Zout(z0), .Vld(v0)
  );

  incdec_acc_p #(.N(N), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .Cin(cin), .A(a), .B(b),
    .Y(y1), .Cout(c1), .Zout(z1), .Vld(v1)
  );

  typedef struct {
    logic         en;
    logic [1:0]   op;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y_wrap;
    logic         c_wrap;
    logic [N-1:0] y_sat;
    logic         c_sat;
  } vec_t;

  typedef struct {
    logic [N-1:0] y_wrap;
    logic         c_wrap;
    logic [N-1:0] y_sat;
    logic         c_sat;
    logic         vld;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [N-1:0] ey, input logic ec, input logic ev);
    chk({tag, " wrap Y"}, 8'(y0), 8'(ey));
    chk({tag, " wrap Cout"}, 8'(c0), 8'(ec));
    chk({tag, " wrap Zout"}, 8'(z0), 8'(ey == '0));
    chk({tag, " wrap Vld"}, 8'(v0), 8'(ev));
    chk({tag, " sat Y"}, 8'(y1), 8'(ey));
    chk({tag, " sat Cout"}, 8'(c1), 8'(ec));
    chk({tag, " sat Vld"}, 8'(v1), 8'(ev));
  endtask

  function automatic vec_t mk(input logic e, input logic [1:0] o, input logic ci,
                              input logic [3:0] av, input logic [3:0] bv,
                              input logic [3:0] yw, input logic cw,
                              input logic [3:0] ys, input logic cs);
    vec_t v;
    v.en = e; v.op = o; v.cin = ci; v.a = av; v.b = bv;
    v.y_wrap = yw; v.c_wrap = cw; v.y_sat = ys; v.c_sat = cs;
    return v;
  endfunction

  initial begin
    exp_t e;
    // en op  cin A     B      Ywrap Cw  Ysat  Cs
    vecs[0]  = mk(0, 2'b10, 0, 4'h3, 4'h9, 4'h0, 0, 4'h0, 0);
    vecs[1]  = mk(1, 2'b01, 0, 4'h5, 4'hA, 4'h5, 0, 4'h5, 0);
    vecs[2]  = mk(1, 2'b01, 1, 4'h5, 4'hA, 4'hA, 0, 4'hA, 0);
    vecs[3]  = mk(1, 2'b01, 0, 4'hF, 4'h1, 4'hF, 0, 4'hF, 0);
    vecs[4]  = mk(1, 2'b10, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 1);
    vecs[5]  = mk(1, 2'b11, 0, 4'h0, 4'h0, 4'hF, 1, 4'hE, 0);
    vecs[6]  = mk(1, 2'b00, 1, 4'h7, 4'h7, 4'hF, 0, 4'hE, 0);
    vecs[7]  = mk(1, 2'b10, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 0);
    vecs[8]  = mk(1, 2'b10, 0, 4'h0, 4'h0, 4'h1, 0, 4'hF, 1);
    vecs[9]  = mk(1, 2'b01, 0, 4'hE, 4'h0, 4'hE, 0, 4'hE, 0);
    vecs[10] = mk(1, 2'b10, 0, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0);
    vecs[11] = mk(1, 2'b10, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 1);
    vecs[12] = mk(1, 2'b01, 0, 4'h0, 4'hC, 4'h0, 0, 4'h0, 0);
    vecs[13] = mk(1, 2'b11, 0, 4'h0, 4'h0, 4'hF, 1, 4'h0, 1);
    vecs[14] = mk(1, 2'b11, 0, 4'h0, 4'h0, 4'hE, 0, 4'h0, 1);
    for (int i = 15; i < 20; i++)
      vecs[i] = mk(0, 2'b10, 1, 4'(i), 4'(~i), 4'hE, 0, 4'h0, 0);
    vecs[20] = mk(1, 2'b01, 1, 4'h9, 4'h3, 4'h3, 0, 4'h3, 0);
    vecs[21] = mk(1, 2'b11, 0, 4'h0, 4'h0, 4'h2, 0, 4'h2, 0);

    rst_n = 1'b0; en = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("in reset wrap Y", 8'(y0), 8'h0);
    chk("in reset wrap Zout", 8'(z0), 8'h1);
    chk("in reset sat Vld", 8'(v1), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      en = vecs[i].en; op = vecs[i].op; cin = vecs[i].cin; a = vecs[i].a; b = vecs[i].b;
      e.y_wrap = vecs[i].y_wrap; e.c_wrap = vecs[i].c_wrap;
      e.y_sat = vecs[i].y_sat; e.c_sat = vecs[i].c_sat; e.vld = vecs[i].en;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("v%0d scoreboard empty", i), 8'h0, 8'h1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d wrap Y", i), 8'(y0), 8'(e.y_wrap));
        chk($sformatf("v%0d wrap Cout", i), 8'(c0), 8'(e.c_wrap));
        chk($sformatf("v%0d wrap Zout", i), 8'(z0), 8'(e.y_wrap == '0));
        chk($sformatf("v%0d wrap Vld", i), 8'(v0), 8'(e.vld));
        chk($sformatf("v%0d sat Y", i), 8'(y1), 8'(e.y_sat));
        chk($sformatf("v%0d sat Cout", i), 8'(c1), 8'(e.c_sat));
        chk($sformatf("v%0d sat Zout", i), 8'(z1), 8'(e.y_sat == '0));
        chk($sformatf("v%0d sat Vld", i), 8'(v1), 8'(e.vld));
      end
    end

    // Reset pulse in the middle of an INC stream sitting at 0111.
    @(negedge clk);
    en = 1'b1; op = 2'b01; cin = 1'b0; a = 4'h6;
    @(posedge clk); #1;
    chk_both("rst load6", 4'h6, 1'b0, 1'b1);
    @(negedge clk);
    op = 2'b10;
    @(posedge clk); #1;
    chk_both("rst inc7", 4'h7, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("rst async", 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_both("rst held edge", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_both("rst resume1", 4'h1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_both("rst resume2", 4'h2, 1'b0, 1'b1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk_both("rst idle", 4'h2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
